// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode seven-segment display
// bank. Each digit gets a slot of SCAN_DIV clocks: BLANK_CYC clocks with every
// anode off (anti-ghosting while the segment bus settles), then the rest of
// the slot with that digit's anode on. Digit data is double-buffered: a load
// lands in a staging register and is promoted to the displayed (shadow) copy
// only at a frame boundary, so a frame never shows a mix of old and new data.
//
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   enable      : scanning runs while high; low parks the FSM in IDLE
//   load        : capture digits_in / dp_in / blank_in this cycle
//   digits_in   : nibble k = hex value of digit k
//   dp_in       : decimal point request per digit, 1 = lit
//   blank_in    : 1 = digit kept dark (e.g. leading zero)
//   digit_val   : value of the current digit, to the hex-to-segment decoder
//   digit_an    : active-low digit enables
//   dp_n        : active-low decimal point
//   frame_done  : one-cycle pulse in the first cycle of each new frame
//   state_dbg   : current FSM state (IDLE=0, BLANK=1, SHOW=2)
//
// All outputs are registers. They are computed from the next-state values in
// the same clock edge that updates the FSM, so an output always describes the
// state the FSM is in during that cycle.
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              digit_val,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    dp_n,
  output logic                    frame_done,
  output logic [1:0]              state_dbg
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  // cnt runs 0..SCAN_DIV-1 across the whole slot; BLANK covers the first
  // BLANK_CYC counts and SHOW the remainder, so the slot length is fixed.
  logic [CNT_W-1:0]        cnt, cnt_nx;

  logic [4*NUM_DIGITS-1:0] shadow_digits, shadow_digits_nx;
  logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nx;
  logic [NUM_DIGITS-1:0]   shadow_blank, shadow_blank_nx;
  logic [4*NUM_DIGITS-1:0] stage_digits, stage_digits_nx;
  logic [NUM_DIGITS-1:0]   stage_dp, stage_dp_nx;
  logic [NUM_DIGITS-1:0]   stage_blank, stage_blank_nx;
  logic                    pending, pending_nx;

  logic                    boundary;

  logic [3:0]              sel_val;
  logic                    sel_dp;
  logic                    sel_blank;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic                    dp_n_nx;
  logic [3:0]              val_nx;

  assign state_dbg = state;

  // Scan sequencing.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    boundary = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = BLANK;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      end
      BLANK, SHOW: begin
        if (!enable) begin
          state_nx = IDLE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            boundary = 1'b1;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          if (state == BLANK && cnt == BLANK_LAST) begin
            state_nx = SHOW;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  // Double-buffered display data. A load while idle or exactly on a frame
  // boundary goes straight to the displayed copy; any other load waits in
  // staging until the next boundary.
  always_comb begin
    shadow_digits_nx = shadow_digits;
    shadow_dp_nx     = shadow_dp;
    shadow_blank_nx  = shadow_blank;
    stage_digits_nx  = stage_digits;
    stage_dp_nx      = stage_dp;
    stage_blank_nx   = stage_blank;
    pending_nx       = pending;
    if (load) begin
      stage_digits_nx = digits_in;
      stage_dp_nx     = dp_in;
      stage_blank_nx  = blank_in;
    end
    if ((state == IDLE || boundary) && load) begin
      shadow_digits_nx = digits_in;
      shadow_dp_nx     = dp_in;
      shadow_blank_nx  = blank_in;
      pending_nx       = 1'b0;
    end else if (boundary && pending) begin
      shadow_digits_nx = stage_digits;
      shadow_dp_nx     = stage_dp;
      shadow_blank_nx  = stage_blank;
      pending_nx       = 1'b0;
    end else if (load) begin
      pending_nx = 1'b1;
    end
  end

  // Output decode from the next-cycle state and data.
  always_comb begin
    sel_val   = 4'd0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nx == IDX_W'(k)) begin
        sel_val   = shadow_digits_nx[4*k +: 4];
        sel_dp    = shadow_dp_nx[k];
        sel_blank = shadow_blank_nx[k];
      end
    end

    an_nx   = '1;
    dp_n_nx = 1'b1;
    val_nx  = 4'd0;
    if (state_nx != IDLE) begin
      val_nx = sel_val;
    end
    if (state_nx == SHOW && !sel_blank) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_nx == IDX_W'(k)) begin
          an_nx[k] = 1'b0;
        end
      end
      dp_n_nx = ~sel_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '0;
      stage_digits  <= '0;
      stage_dp      <= '0;
      stage_blank   <= '0;
      pending       <= 1'b0;
      digit_an      <= '1;
      digit_val     <= 4'd0;
      dp_n          <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      cnt           <= cnt_nx;
      shadow_digits <= shadow_digits_nx;
      shadow_dp     <= shadow_dp_nx;
      shadow_blank  <= shadow_blank_nx;
      stage_digits  <= stage_digits_nx;
      stage_dp      <= stage_dp_nx;
      stage_blank   <= stage_blank_nx;
      pending       <= pending_nx;
      digit_an      <= an_nx;
      digit_val     <= val_nx;
      dp_n          <= dp_n_nx;
      frame_done    <= boundary;
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot (blank plus show).
REQ-003 The block SHALL have parameter BLANK_CYC, default 1000, anti-ghost blank clocks per slot; 1 <= BLANK_CYC < SCAN_DIV.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: scanning runs while high.
REQ-008 The block SHALL have port load, input, 1 bit: capture digits_in/dp_in/blank_in this cycle.
REQ-009 The block SHALL have port digits_in, input, 4*NUM_DIGITS bits: nibble k is the hex value of digit k.
REQ-010 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal point request per digit, 1 = lit.
REQ-011 The block SHALL have port blank_in, input, NUM_DIGITS bits: 1 = digit kept dark, e.g. leading zero.
REQ-012 The block SHALL have port digit_val, output, 4 bits: value of the current digit, to the hex-to-segment decoder.
REQ-013 The block SHALL have port digit_an, output, NUM_DIGITS bits: active-low digit enables.
REQ-014 The block SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have states IDLE, BLANK and SHOW, a digit index idx (0..NUM_DIGITS-1) and a slot counter cnt.
REQ-018 IDLE SHALL drive digit_an all ones and dp_n=1; when enable=1, the next state SHALL be BLANK with idx=0 and cnt=0.
REQ-019 BLANK SHALL drive digit_an all ones, dp_n=1 and digit_val=shadow nibble idx; after exactly BLANK_CYC cycles the FSM SHALL enter SHOW.
REQ-020 SHOW SHALL last exactly SCAN_DIV-BLANK_CYC cycles.
REQ-021 In SHOW, digit_an bit idx SHALL be 0 unless shadow blank bit idx=1, and all other bits SHALL be 1.
REQ-022 In SHOW, dp_n SHALL be the inverse of shadow dp bit idx, and forced to 1 when that digit is blanked.
REQ-023 At the end of SHOW with idx<NUM_DIGITS-1, idx SHALL increment and the FSM SHALL enter BLANK.
REQ-024 At the end of SHOW with idx=NUM_DIGITS-1 (frame boundary), idx SHALL wrap to 0, the FSM SHALL enter BLANK, and frame_done SHALL pulse high for exactly that one cycle.
REQ-025 A digit period SHALL be exactly SCAN_DIV clocks and a frame exactly NUM_DIGITS*SCAN_DIV clocks.
REQ-026 When enable=0 in any state, the next cycle SHALL be IDLE with idx=0, cnt=0 and anodes off; frame_done SHALL NOT pulse.
REQ-027 load=1 SHALL copy all three inputs into a staging register and set pending; with consecutive load cycles, the last one wins.
REQ-028 At a frame boundary with pending=1, staging SHALL copy to shadow and pending SHALL clear, so displayed data never changes mid-frame.
REQ-029 When load=1 coincides with a frame boundary, that cycle's inputs SHALL go directly to shadow and pending SHALL end 0.
REQ-030 When load=1 in IDLE, the inputs SHALL be written to both staging and shadow, leaving pending=0.
REQ-031 cnt SHALL be wide enough for SCAN_DIV-1 and SHALL never overflow.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL enter IDLE with idx=0, cnt=0, digit_an all ones, digit_val=0, dp_n=1, frame_done=0, shadow=0, staging=0 and pending=0.
REQ-033 rst SHALL take priority over enable and load.
REQ-034 Reset asserted mid-slot SHALL turn all anodes off on the next cycle, and any pending load SHALL be discarded.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1)
REQ-035 Apply rst, then hold enable=0 for 10 cycles -> digit_an=4'hF, dp_n=1, digit_val=0, frame_done never high.
REQ-036 In IDLE, load digits_in=16'h4321, dp_in=4'b0010, blank_in=0, then set enable=1 -> per 4-cycle slot: 1 blank cycle, then 3 cycles of digit_an=1110/1101/1011/0111 with digit_val=1/2/3/4; dp_n=0 only during the digit-1 show; frame_done pulses every 16 cycles.
REQ-037 While running, load 16'h8888 in mid-frame during digit 1 -> digits 2 and 3 still show 3 and 4; from the next frame all digits show 8.
REQ-038 Load blank_in=4'b1000 with dp_in=4'b1000 -> digit_an bit 3 stays 1 and dp_n stays 1 through digit 3's slot; slot timing is unchanged.
REQ-039 Drop enable during digit 2's SHOW -> next cycle digit_an=4'hF; on re-enable, scanning restarts at digit 0 after one blank cycle.
REQ-040 Assert rst for 1 cycle mid-frame with a pending load -> IDLE outputs as in REQ-032; after re-enable, digit_val=0 for all digits.
